// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED bar/dot sequencer.
// Mode and display selector constants.
package led_seq_pkg;

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam logic DISP_BAR = 1'b0;
    localparam logic DISP_DOT = 1'b1;

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: one tick every DIV enabled cycles.
// A clear restarts the count so the next tick is DIV enabled cycles away.
module led_tick_gen #(
    parameter int DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    assign tick = en && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_bar_sequencer.sv
// LED bar/dot sequencer: bounded level counter stepped by a prescaler,
// rendered through a registered bar or single-dot encoder.
module led_bar_sequencer
    import led_seq_pkg::*;
#(
    parameter int   LED_N = 16,
    parameter int   DIV   = 25_000_000,
    localparam int  CW    = $clog2(LED_N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    start_num,
    input  logic [CW-1:0]    end_num,
    input  logic [1:0]       mode,
    input  logic             disp,
    input  logic             en,
    input  logic             load,
    output logic [LED_N-1:0] led_out,
    output logic [CW-1:0]    level,
    output logic             dir,
    output logic             wrap
);

    localparam logic [CW-1:0] MAXV = CW'(LED_N);

    logic [CW-1:0]    r_level;
    logic             r_dir;
    logic             r_wrap;
    logic [LED_N-1:0] r_led;

    logic [CW-1:0]    w_s;
    logic [CW-1:0]    w_e;
    logic [CW-1:0]    w_lo;
    logic [CW-1:0]    w_hi;
    logic             w_tick;
    logic             w_up;
    logic [CW-1:0]    w_nlvl;
    logic             w_ndir;
    logic             w_nwrap;
    logic [LED_N-1:0] w_enc;

    assign w_s  = (start_num > MAXV) ? MAXV : start_num;
    assign w_e  = (end_num > MAXV) ? MAXV : end_num;
    assign w_lo = (w_s < w_e) ? w_s : w_e;
    assign w_hi = (w_s < w_e) ? w_e : w_s;

    led_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (w_tick)
    );

    always_comb begin
        w_nlvl  = r_level;
        w_ndir  = r_dir;
        w_nwrap = 1'b0;
        w_up    = (mode == MODE_UP) || ((mode == MODE_BOUNCE) && r_dir);
        if (load) begin
            w_nlvl = w_s;
            w_ndir = (mode != MODE_DOWN);
        end else if (w_tick && (mode != MODE_HOLD)) begin
            // Bounds moved under a running level: snap into range
            if ((r_level < w_lo) || (r_level > w_hi)) begin
                w_nlvl  = w_up ? w_lo : w_hi;
                w_nwrap = 1'b1;
            end else begin
                case (mode)
                    MODE_UP: begin
                        if (r_level < w_hi) begin
                            w_nlvl = r_level + 1'b1;
                        end else begin
                            w_nlvl  = w_lo;
                            w_nwrap = 1'b1;
                        end
                    end
                    MODE_DOWN: begin
                        if (r_level > w_lo) begin
                            w_nlvl = r_level - 1'b1;
                        end else begin
                            w_nlvl  = w_hi;
                            w_nwrap = 1'b1;
                        end
                    end
                    MODE_BOUNCE: begin
                        if (r_dir) begin
                            if (r_level < w_hi) begin
                                w_nlvl = r_level + 1'b1;
                                if ((r_level + 1'b1) == w_hi) begin
                                    w_ndir  = 1'b0;
                                    w_nwrap = 1'b1;
                                end
                            end else begin
                                w_nlvl  = (w_lo == w_hi) ? r_level : r_level - 1'b1;
                                w_ndir  = 1'b0;
                                w_nwrap = 1'b1;
                            end
                        end else begin
                            if (r_level > w_lo) begin
                                w_nlvl = r_level - 1'b1;
                                if ((r_level - 1'b1) == w_lo) begin
                                    w_ndir  = 1'b1;
                                    w_nwrap = 1'b1;
                                end
                            end else begin
                                w_nlvl  = (w_lo == w_hi) ? r_level : r_level + 1'b1;
                                w_ndir  = 1'b1;
                                w_nwrap = 1'b1;
                            end
                        end
                    end
                    default: begin
                        w_nlvl = r_level;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_enc = '0;
        for (int i = 0; i < LED_N; i++) begin
            if (disp == DISP_DOT) begin
                w_enc[i] = (CW'(i + 1) == r_level);
            end else begin
                w_enc[i] = (CW'(i) < r_level);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
            r_dir   <= 1'b1;
            r_wrap  <= 1'b0;
            r_led   <= '0;
        end else begin
            r_level <= w_nlvl;
            r_dir   <= w_ndir;
            r_wrap  <= w_nwrap;
            r_led   <= w_enc;
        end
    end

    assign led_out = r_led;
    assign level   = r_level;
    assign dir     = r_dir;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_led_bar_sequencer.sv
// Scoreboard bench for led_bar_sequencer: DIV=1 instance for stepping
// and encoding, DIV=4 instance for prescaler spacing and priority.
module tb_led_bar_sequencer;
    import led_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, load, en4, load4, disp;
    logic [1:0]  mode;
    logic [4:0]  start_num, end_num;
    logic [15:0] led1, led4;
    logic [4:0]  lvl1, lvl4;
    logic        dir1, dir4, wrap1, wrap4;

    led_bar_sequencer #(.LED_N(16), .DIV(1)) u_dut (
        .clk(clk), .rst(rst), .start_num(start_num), .end_num(end_num),
        .mode(mode), .disp(disp), .en(en), .load(load),
        .led_out(led1), .level(lvl1), .dir(dir1), .wrap(wrap1)
    );

    led_bar_sequencer #(.LED_N(16), .DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_num(start_num), .end_num(end_num),
        .mode(mode), .disp(disp), .en(en4), .load(load4),
        .led_out(led4), .level(lvl4), .dir(dir4), .wrap(wrap4)
    );

    typedef struct {
        int sel;
        int lvl;
        int dir;
        int wrap;
        int led;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;
    int   prev_lvl = 0;

    function automatic int enc(input int l, input logic d);
        if (d == DISP_DOT) return (l == 0) ? 0 : (1 << (l - 1));
        return (1 << l) - 1;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // push expectation, clock the DUTs, pop and compare
    task automatic step(input string tag, input int sel, input int lvl,
                        input int d, input int w, input int led);
        exp_t e;
        sb.push_back('{sel, lvl, d, w, led});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.sel == 0) begin
            chk({tag, ".lvl"}, int'(lvl1), e.lvl);
            chk({tag, ".wrap"}, int'(wrap1), e.wrap);
            if (e.dir >= 0) chk({tag, ".dir"}, int'(dir1), e.dir);
            if (e.led >= 0) chk({tag, ".led"}, int'(led1), e.led);
        end else begin
            chk({tag, ".lvl4"}, int'(lvl4), e.lvl);
            chk({tag, ".wrap4"}, int'(wrap4), e.wrap);
            if (e.dir >= 0) chk({tag, ".dir4"}, int'(dir4), e.dir);
            if (e.led >= 0) chk({tag, ".led4"}, int'(led4), e.led);
        end
    endtask

    task automatic step1(input string tag, input int lvl, input int d, input int w);
        step(tag, 0, lvl, d, w, enc(prev_lvl, disp));
        prev_lvl = lvl;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int up_l[5]   = '{4, 5, 6, 3, 4};
        int up_w[5]   = '{0, 0, 0, 1, 0};
        int bn_l[5]   = '{3, 4, 3, 2, 3};
        int bn_d[5]   = '{1, 0, 0, 1, 1};
        int bn_w[5]   = '{0, 1, 0, 1, 0};
        int dn_l[6]   = '{9, 8, 7, 6, 5, 10};
        rst = 1'b1; en = 1'b1; load = 1'b0; en4 = 1'b1; load4 = 1'b0;
        mode = MODE_UP; disp = DISP_BAR; start_num = 5'd0; end_num = 5'd0;

        step("rst", 0, 0, 1, 0, 0);
        step("rst", 1, 0, 1, 0, 0);
        rst = 1'b0;
        prev_lvl = 0;

        start_num = 5'd3; end_num = 5'd6; load = 1'b1;
        step1("up_ld", 3, 1, 0);
        load = 1'b0;
        for (int i = 0; i < 5; i++) step1("up", up_l[i], 1, up_w[i]);

        rst = 1'b1;
        step("rst_mid", 0, 0, 1, 0, 0);
        rst = 1'b0;
        prev_lvl = 0;

        start_num = 5'd2; end_num = 5'd4; mode = MODE_BOUNCE; load = 1'b1;
        step1("bn_ld", 2, 1, 0);
        load = 1'b0;
        for (int i = 0; i < 5; i++) step1("bn", bn_l[i], bn_d[i], bn_w[i]);

        start_num = 5'd10; end_num = 5'd5; mode = MODE_DOWN; load = 1'b1;
        step1("dn_ld", 10, 0, 0);
        load = 1'b0;
        for (int i = 0; i < 6; i++) step1("dn", dn_l[i], 0, (i == 5) ? 1 : 0);

        start_num = 5'd3; end_num = 5'd6; mode = MODE_UP; load = 1'b1;
        step1("oor_ld", 3, 1, 0);
        load = 1'b0; start_num = 5'd8; end_num = 5'd12;
        step1("oor_snap", 8, 1, 1);
        step1("oor_next", 9, 1, 0);

        start_num = 5'd5; end_num = 5'd5; load = 1'b1;
        step1("deg_ld", 5, 1, 0);
        load = 1'b0;
        step1("deg", 5, 1, 1);
        step1("deg", 5, 1, 1);

        start_num = 5'd15; end_num = 5'd20; load = 1'b1;
        step1("clmp_ld", 15, 1, 0);
        load = 1'b0;
        step1("clmp_top", 16, 1, 0);
        step1("clmp_wrap", 15, 1, 1);

        disp = DISP_DOT; mode = MODE_HOLD; start_num = 5'd0; end_num = 5'd0;
        load = 1'b1;
        step1("dot_ld0", 0, -1, 0);
        load = 1'b0;
        step1("dot0", 0, -1, 0);
        start_num = 5'd1; load = 1'b1;
        step1("dot_ld1", 1, -1, 0);
        load = 1'b0;
        step1("dot1", 1, -1, 0);
        start_num = 5'd20; load = 1'b1;
        step1("dot_ld16", 16, -1, 0);
        load = 1'b0;
        step1("dot16", 16, -1, 0);
        disp = DISP_BAR;
        step1("bar16", 16, -1, 0);

        en = 1'b0; mode = MODE_UP; start_num = 5'd3; end_num = 5'd6;
        load4 = 1'b1;
        step("p_ld", 1, 3, 1, 0, -1);
        load4 = 1'b0; en4 = 1'b0;
        for (int i = 0; i < 10; i++) step("p_en0", 1, 3, 1, 0, -1);
        en4 = 1'b1;
        for (int i = 0; i < 3; i++) step("p_wait", 1, 3, 1, 0, -1);
        step("p_step", 1, 4, 1, 0, -1);
        step("p_c1", 1, 4, 1, 0, -1);
        step("p_c2", 1, 4, 1, 0, -1);
        load4 = 1'b1;
        step("p_reld", 1, 3, 1, 0, -1);
        load4 = 1'b0;
        for (int i = 0; i < 3; i++) step("p_wait2", 1, 3, 1, 0, -1);
        step("p_step2", 1, 4, 1, 0, -1);
        for (int i = 0; i < 3; i++) step("p_wait3", 1, 4, 1, 0, -1);
        load4 = 1'b1;
        step("p_ld_tick", 1, 3, 1, 0, -1);
        load4 = 1'b0;
        for (int i = 0; i < 3; i++) step("p_wait4", 1, 3, 1, 0, -1);
        step("p_step4", 1, 4, 1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
